cnt_updn: RTL

CNT_UPDN -- requirements
Module: cnt_updn

---
 rtl/cnt_updn.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cnt_updn.sv
// Up/down counter with free-running wrap/saturate mode and a start-triggered
// run-to-terminal sequence (IDLE -> RUN -> DONE).
module cnt_updn #(
  parameter int          SIZE_ = 8,
  parameter int unsigned STEP_ = 1,
  parameter bit          SAT_  = 1'b0
) (
  input  logic             clk_,
  input  logic             rst_n_,
  input  logic             en_,
  input  logic             load_cnt_,
  input  logic             dir_,
  input  logic             start_,
  input  logic [SIZE_-1:0] d_,
  input  logic [SIZE_-1:0] lim_,
  output logic [SIZE_-1:0] q_,
  output logic             tc_,
  output logic             ovf_,
  output logic             busy_,
  output logic             done_
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [SIZE_:0] STEP_X = (SIZE_+1)'(STEP_);

  state_t           state_q, state_d;
  logic [SIZE_-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [SIZE_-1:0] q_free, q_run;
  logic             ovf_free, hit_run;

  // Free-mode step: returns {boundary_event, next_q}; wrap or clamp per SAT_.
  function automatic logic [SIZE_:0] free_step(input logic [SIZE_-1:0] q,
                                               input logic [SIZE_-1:0] lim,
                                               input logic up);
    logic [SIZE_:0]   sum;
    logic [SIZE_-1:0] nq;
    logic             ov;
    sum = {1'b0, q} + STEP_X;
    nq  = q;
    ov  = 1'b0;
    if (up) begin
      if (sum <= {1'b0, lim}) nq = sum[SIZE_-1:0];
      else if (!SAT_) begin nq = '0; ov = 1'b1; end
      else if (q != lim) begin nq = lim; ov = 1'b1; end
    end else begin
      if ({1'b0, q} >= STEP_X) nq = q - STEP_X[SIZE_-1:0];
      else if (!SAT_) begin nq = lim; ov = 1'b1; end
      else if (q != '0) begin nq = '0; ov = 1'b1; end
    end
    return {ov, nq};
  endfunction

  // Run-mode step: always clamps to the terminal; returns {reached, next_q}.
  function automatic logic [SIZE_:0] run_step(input logic [SIZE_-1:0] q,
                                              input logic [SIZE_-1:0] lim,
                                              input logic up);
    logic [SIZE_:0] sum;
    sum = {1'b0, q} + STEP_X;
    if (up) begin
      if (sum >= {1'b0, lim}) return {1'b1, lim};
      return {1'b0, sum[SIZE_-1:0]};
    end
    if ({1'b0, q} <= STEP_X) return {1'b1, {SIZE_{1'b0}}};
    return {1'b0, q - STEP_X[SIZE_-1:0]};
  endfunction

  always_comb begin
    {ovf_free, q_free} = free_step(q_q, lim_, dir_);
    {hit_run, q_run}   = run_step(q_q, lim_, dir_);
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    ovf_d   = 1'b0;
    done_d  = 1'b0;
    if (load_cnt_) begin
      q_d     = d_;
      state_d = IDLE;
    end else if (state_q == IDLE && start_) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (en_) begin
        q_d = q_run;
        if (hit_run) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
    end else begin
      // IDLE or DONE: DONE always falls back to IDLE, both may free-step.
      state_d = IDLE;
      if (en_) begin
        q_d   = q_free;
        ovf_d = ovf_free;
      end
    end
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk_) begin
    if (!rst_n_) begin
      state_q <= IDLE;
      q_q     <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q_    = q_q;
  assign ovf_  = ovf_q;
  assign busy_ = busy_q;
  assign done_ = done_q;
  assign tc_   = dir_ ? (q_q == lim_) : (q_q == '0);

endmodule
